// File: rtl/hazard_pkg.sv
// Shared types and helpers for the uRISC hazard/forwarding controller.
package hazard_pkg;

  // Stored destination width; wide enough for register files up to 256 entries.
  localparam int HZ_IDX_W = 8;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int FWD_REGFILE = 0;

  // One tracked in-flight instruction.
  typedef struct packed {
    logic                valid;
    logic [HZ_IDX_W-1:0] dest;
    logic                wr;
    logic                is_load;
  } hz_entry_t;

  // Select width: value 0 is the regfile, values 1..depth are pipeline stages.
  function automatic int sel_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Priority match of one decode source operand against the tracked writers.
// The youngest (lowest stage index) valid writer of the register decides:
// either it can be forwarded from its stage, or it raises a hazard.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int SEL_W      = sel_w(PIPE_DEPTH)
) (
  input  logic                           req_i,
  input  logic [HZ_IDX_W-1:0]            src_i,
  input  hz_entry_t [PIPE_DEPTH-1:0]     entries_i,
  output logic                           hazard_o,
  output logic [SEL_W-1:0]               sel_o
);

  logic found;

  // Scan from the youngest stage outward; the first matching writer wins.
  always_comb begin
    hazard_o = 1'b0;
    sel_o    = SEL_W'(FWD_REGFILE);
    found    = 1'b0;
    if (req_i) begin
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        if (!found && entries_i[k-1].valid && entries_i[k-1].wr &&
            (entries_i[k-1].dest == src_i)) begin
          found = 1'b1;
          if (entries_i[k-1].is_load && (k < LOAD_AVAIL)) begin
            hazard_o = 1'b1;
          end else begin
            sel_o = SEL_W'(k);
          end
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and forwarding controller for the uRISC core.
// Tracks writers in the stages after decode, stalls decode on unresolved
// load-use hazards, produces per-source forwarding selects, a pending-writer
// bitmap and a saturating stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int NUM_REGS   = 8,
  parameter  int NUM_SRC    = 2,
  parameter  int PIPE_DEPTH = 3,
  parameter  int LOAD_AVAIL = 2,
  parameter  int CNT_W      = 16,
  localparam int REG_IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int SEL_W      = sel_w(PIPE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid_p1,
  input  logic [NUM_SRC*REG_IDX_W-1:0] id_src_idx_p1,
  input  logic [NUM_SRC-1:0]           id_src_valid_p1,
  input  logic [REG_IDX_W-1:0]         id_dest_idx_p1,
  input  logic                         id_dest_wr_p1,
  input  logic                         id_is_load_p1,
  input  logic                         flush_p1,
  input  logic                         halt_p1,
  output logic                         stall_id_p1,
  output logic                         bubble_ix_p1,
  output logic [NUM_SRC*SEL_W-1:0]     fwd_sel_p1,
  output logic [NUM_REGS-1:0]          busy_p1,
  output logic [CNT_W-1:0]             stall_cnt_p1
);

  // Index 0 models stage 1 (idix), index PIPE_DEPTH-1 models the last stage.
  hz_entry_t [PIPE_DEPTH-1:0] entries_q, entries_d;
  logic [NUM_SRC-1:0]         src_hazard;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;

  // One priority matcher per source operand.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(
      .PIPE_DEPTH (PIPE_DEPTH),
      .LOAD_AVAIL (LOAD_AVAIL),
      .SEL_W      (SEL_W)
    ) u_match (
      .req_i     (id_valid_p1 & id_src_valid_p1[i]),
      .src_i     (HZ_IDX_W'(id_src_idx_p1[i*REG_IDX_W +: REG_IDX_W])),
      .entries_i (entries_q),
      .hazard_o  (src_hazard[i]),
      .sel_o     (fwd_sel_p1[i*SEL_W +: SEL_W])
    );
  end

  // A redirect discards the decode instruction, so it never needs to wait.
  assign stall_id_p1  = (|src_hazard) & ~flush_p1;
  assign bubble_ix_p1 = stall_id_p1 | flush_p1 | halt_p1 | ~id_valid_p1;
  assign stall_cnt_p1 = stall_cnt_q;

  // Pending-writer bitmap built only from tracked entries.
  always_comb begin
    busy_p1 = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        if (entries_q[k].valid && entries_q[k].wr &&
            (entries_q[k].dest == HZ_IDX_W'(r))) begin
          busy_p1[r] = 1'b1;
        end
      end
    end
  end

  // Later stages always advance; stage 1 takes decode or a bubble.
  always_comb begin
    entries_d = entries_q;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      entries_d[k] = entries_q[k-1];
    end
    if (bubble_ix_p1) begin
      entries_d[0] = '0;
    end else begin
      entries_d[0].valid   = 1'b1;
      entries_d[0].dest    = HZ_IDX_W'(id_dest_idx_p1);
      entries_d[0].wr      = id_dest_wr_p1;
      entries_d[0].is_load = id_is_load_p1;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall_id_p1 && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
